// File: rtl/cipher_runner_pkg.sv
// Shared types and sizing helpers for the cipher test-vector runner.
package cipher_runner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_UUT_RST = 3'd2,
    ST_RUN     = 3'd3,
    ST_EMIT    = 3'd4
  } state_e;

  localparam int unsigned STAT_PASS    = 0;
  localparam int unsigned STAT_TIMEOUT = 1;

  function automatic int unsigned KEY_BYTES(input int unsigned key_width);
    return key_width / 8;
  endfunction

  function automatic int unsigned BLK_BYTES(input int unsigned block_width);
    return block_width / 8;
  endfunction

  // Flags byte, key, input block, expected block.
  function automatic int unsigned VEC_BYTES(input int unsigned key_width,
                                            input int unsigned block_width);
    return 1 + KEY_BYTES(key_width) + 2 * BLK_BYTES(block_width);
  endfunction

  // Status byte, latency count, UUT output block.
  function automatic int unsigned REC_BYTES(input int unsigned block_width,
                                            input int unsigned cnt_width);
    return 1 + cnt_width / 8 + BLK_BYTES(block_width);
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Parallel-load, MSB-first byte shifter with valid/ready output handshake.
module byte_serializer #(
  parameter int unsigned NBYTES = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [NBYTES*8-1:0]   load_data,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  last_fire
);

  localparam int unsigned CW = $clog2(NBYTES + 1);

  logic [NBYTES*8-1:0] sh_q, sh_d;
  logic [CW-1:0]       left_q, left_d;
  logic                valid_q, valid_d;
  logic                fire_s;

  // Next-state for the shift register and remaining-byte count.
  always_comb begin
    sh_d      = sh_q;
    left_d    = left_q;
    valid_d   = valid_q;
    fire_s    = valid_q && out_ready;
    last_fire = fire_s && (left_q == CW'(1));
    if (load) begin
      sh_d    = load_data;
      left_d  = CW'(NBYTES);
      valid_d = 1'b1;
    end else if (fire_s) begin
      sh_d    = {sh_q[NBYTES*8-9:0], 8'h00};
      left_d  = left_q - CW'(1);
      valid_d = (left_q != CW'(1));
    end else begin
      valid_d = valid_q;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q    <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      left_q  <= left_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = sh_q[NBYTES*8-1 -: 8];
  assign out_valid = valid_q;

endmodule

// File: rtl/cipher_vector_runner.sv
// Streaming test-vector sequencer: loads a vector, resets and runs the UUT,
// times it, checks the result and streams out a result record.
module cipher_vector_runner
  import cipher_runner_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH    = 64,
  parameter int unsigned KEY_WIDTH      = 80,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   rst_uut,
  output logic [BLOCK_WIDTH-1:0] block_i_uut,
  output logic [KEY_WIDTH-1:0]   key_uut,
  output logic                   encdec_uut,
  input  logic [BLOCK_WIDTH-1:0] block_o_uut,
  input  logic                   end_uut,
  input  logic                   clr_cnt,
  output logic                   busy,
  output logic [15:0]            pass_cnt,
  output logic [15:0]            fail_cnt
);

  localparam int unsigned KB  = KEY_BYTES(KEY_WIDTH);
  localparam int unsigned BB  = BLK_BYTES(BLOCK_WIDTH);
  localparam int unsigned LB  = VEC_BYTES(KEY_WIDTH, BLOCK_WIDTH) - 1;
  localparam int unsigned RB  = REC_BYTES(BLOCK_WIDTH, CNT_WIDTH);
  localparam int unsigned BCW = $clog2(LB + 1);
  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

  state_e                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   rst_uut_q, rst_uut_d;
  logic                   busy_q, busy_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [BLOCK_WIDTH-1:0] blk_q, blk_d;
  logic [BLOCK_WIDTH-1:0] exp_q, exp_d;
  logic                   enc_q, enc_d;
  logic                   flag_q, flag_d;
  logic [BCW-1:0]         bcnt_q, bcnt_d;
  logic [RCW-1:0]         rcnt_q, rcnt_d;
  logic [CNT_WIDTH-1:0]   lat_q, lat_d;
  logic [15:0]            pass_cnt_q, pass_cnt_d;
  logic [15:0]            fail_cnt_q, fail_cnt_d;

  logic                   accept_s, ser_load_s, pass_s, timeout_s, done_s;
  logic [CNT_WIDTH-1:0]   cnt_s;
  logic [7:0]             status_s;

  // Sequencer next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    blk_d      = blk_q;
    exp_d      = exp_q;
    enc_d      = enc_q;
    flag_d     = flag_q;
    bcnt_d     = bcnt_q;
    rcnt_d     = rcnt_q;
    lat_d      = lat_q;
    ser_load_s = 1'b0;
    pass_s     = 1'b0;
    timeout_s  = 1'b0;
    cnt_s      = lat_q;
    accept_s   = in_valid && in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          flag_d  = in_data[0];
          bcnt_d  = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (bcnt_q < BCW'(KB)) begin
            key_d = {key_q[KEY_WIDTH-9:0], in_data};
          end else if (bcnt_q < BCW'(KB + BB)) begin
            blk_d = {blk_q[BLOCK_WIDTH-9:0], in_data};
          end else begin
            exp_d = {exp_q[BLOCK_WIDTH-9:0], in_data};
          end
          if (bcnt_q == BCW'(LB - 1)) begin
            enc_d   = flag_q;
            rcnt_d  = '0;
            state_d = ST_UUT_RST;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_UUT_RST: begin
        lat_d = '0;
        if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      ST_RUN: begin
        if (end_uut) begin
          pass_s     = (block_o_uut == exp_q);
          ser_load_s = 1'b1;
          state_d    = ST_EMIT;
        end else if ((lat_q + CNT_WIDTH'(1)) == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
          lat_d      = lat_q + CNT_WIDTH'(1);
          cnt_s      = lat_q + CNT_WIDTH'(1);
          timeout_s  = 1'b1;
          ser_load_s = 1'b1;
          state_d    = ST_EMIT;
        end else begin
          lat_d = lat_q + CNT_WIDTH'(1);
        end
      end
      ST_EMIT: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    status_s               = 8'h00;
    status_s[STAT_PASS]    = pass_s;
    status_s[STAT_TIMEOUT] = timeout_s;

    // A same-cycle clear wins over the increment.
    if (clr_cnt) begin
      pass_cnt_d = 16'h0000;
      fail_cnt_d = 16'h0000;
    end else begin
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      if (ser_load_s && pass_s && (pass_cnt_q != 16'hFFFF)) begin
        pass_cnt_d = pass_cnt_q + 16'h0001;
      end else if (ser_load_s && !pass_s && (fail_cnt_q != 16'hFFFF)) begin
        fail_cnt_d = fail_cnt_q + 16'h0001;
      end else begin
        pass_cnt_d = pass_cnt_q;
      end
    end

    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    rst_uut_d  = (state_d != ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      rst_uut_q  <= 1'b1;
      busy_q     <= 1'b0;
      key_q      <= '0;
      blk_q      <= '0;
      exp_q      <= '0;
      enc_q      <= 1'b0;
      flag_q     <= 1'b0;
      bcnt_q     <= '0;
      rcnt_q     <= '0;
      lat_q      <= '0;
      pass_cnt_q <= 16'h0000;
      fail_cnt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      rst_uut_q  <= rst_uut_d;
      busy_q     <= busy_d;
      key_q      <= key_d;
      blk_q      <= blk_d;
      exp_q      <= exp_d;
      enc_q      <= enc_d;
      flag_q     <= flag_d;
      bcnt_q     <= bcnt_d;
      rcnt_q     <= rcnt_d;
      lat_q      <= lat_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  byte_serializer #(.NBYTES(RB)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load_s),
    .load_data ({status_s, cnt_s, block_o_uut}),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last_fire (done_s)
  );

  assign in_ready    = in_ready_q;
  assign rst_uut     = rst_uut_q;
  assign busy        = busy_q;
  assign key_uut     = key_q;
  assign block_i_uut = blk_q;
  assign encdec_uut  = enc_q;
  assign pass_cnt    = pass_cnt_q;
  assign fail_cnt    = fail_cnt_q;

endmodule
